// File: rtl/max_pool_pkg.sv
// ============================================================================
// Module      : max_pool_pkg
// Description : Shared defaults and sizing helpers for the max-pooling unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package max_pool_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_KERNEL_DIM = 3;

    function automatic int win_len(input int k);
        return k * k;
    endfunction

    // A window of one pixel still needs a 1-bit counter so the logic stays uniform.
    function automatic int cnt_width(input int k);
        int w;
        w = $clog2(k * k);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : max_pool_pkg

`default_nettype wire

// File: rtl/max_pool_cmp.sv
// ============================================================================
// Module      : max_pool_cmp
// Description : Combinational two-input maximum. Signed compare when
//               MAX_POOL_SIGNED_EN is defined, unsigned otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_pool_cmp #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

`ifdef MAX_POOL_SIGNED_EN
    assign y = ($signed(a) > $signed(b)) ? a : b;
`else
    assign y = (a > b) ? a : b;
`endif

endmodule : max_pool_cmp

`default_nettype wire

// File: rtl/max_pooling_unit.sv
// ============================================================================
// Module      : max_pooling_unit
// Description : Streaming KERNEL_DIM x KERNEL_DIM max-pool reducer, one pixel
//               per clock, no stall. MAX_POOL_SIGNED_EN selects signed pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_pooling_unit
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_DIM = DEFAULT_KERNEL_DIM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] inputPixel,
    output logic [DATA_WIDTH-1:0] outputPixel,
    output logic                  outputValid
);

    localparam int WIN = win_len(KERNEL_DIM);
    localparam int CW  = cnt_width(KERNEL_DIM);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIN - 1);

    // Identity element for the running max: 0 unsigned, most-negative signed.
    function automatic logic [DATA_WIDTH-1:0] min_value();
        logic [DATA_WIDTH-1:0] v;
        v = '0;
`ifdef MAX_POOL_SIGNED_EN
        v[DATA_WIDTH-1] = 1'b1;
`endif
        return v;
    endfunction

    localparam logic [DATA_WIDTH-1:0] MIN_VAL = min_value();

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] run_max;
    logic [DATA_WIDTH-1:0] cand_max;

    max_pool_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .a (run_max),
        .b (inputPixel),
        .y (cand_max)
    );

    // The last pixel of a window goes straight to the output so the next
    // window can start on the following edge without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            run_max     <= MIN_VAL;
            outputPixel <= '0;
            outputValid <= 1'b0;
        end else if (count == LAST_IDX) begin
            count       <= '0;
            run_max     <= MIN_VAL;
            outputPixel <= cand_max;
            outputValid <= 1'b1;
        end else begin
            count       <= count + CW'(1);
            run_max     <= cand_max;
            outputValid <= 1'b0;
        end
    end

endmodule : max_pooling_unit

`default_nettype wire

// File: tb/tb_max_pooling_unit.sv
// ============================================================================
// Module      : tb_max_pooling_unit
// Description : Directed scoreboard bench for max_pooling_unit (3x3 and 1x1);
//               expectations follow MAX_POOL_SIGNED_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max_pooling_unit;

    localparam int DW  = 8;
    localparam int WIN = 9;

    logic          clk;
    logic          rst;
    logic [DW-1:0] pix;
    logic [DW-1:0] out_pix;
    logic          out_valid;
    logic [DW-1:0] pix1;
    logic [DW-1:0] out_pix1;
    logic          out_valid1;

    int errors;
    int checks;

    logic [DW-1:0] win_q[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] held;
    logic          exp_valid;

    max_pooling_unit #(.DATA_WIDTH(DW), .KERNEL_DIM(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .inputPixel  (pix),
        .outputPixel (out_pix),
        .outputValid (out_valid)
    );

    max_pooling_unit #(.DATA_WIDTH(DW), .KERNEL_DIM(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .inputPixel  (pix1),
        .outputPixel (out_pix1),
        .outputValid (out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAX_POOL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, let the model decide whether a window completes,
    // then compare outputs just after the sampling edge.
    task automatic step(input logic [DW-1:0] p);
        logic [DW-1:0] m;
        pix = p;
        win_q.push_back(p);
        if (win_q.size() == WIN) begin
            m = win_q[0];
            foreach (win_q[i]) if (gt(win_q[i], m)) m = win_q[i];
            sb.push_back(m);
            win_q.delete();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid && sb.size() > 0) held = sb.pop_front();
        check("pixel", 32'(out_pix), 32'(held));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        held      = '0;
        exp_valid = 1'b0;
        rst       = 1'b0;
        pix       = '0;
        pix1      = '0;

        #12;
        check("rst_pix", 32'(out_pix), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_pix_k1", 32'(out_pix1), 32'h0);
        check("rst_valid_k1", 32'(out_valid1), 32'h0);
        rst = 1'b1;

        // Ascending 1..9
        for (int i = 1; i <= 9; i++) step(DW'(i));
        // Descending 255..247 then a window of zeros
        for (int i = 0; i < 9; i++) step(DW'(255 - i));
        for (int i = 0; i < 9; i++) step(8'd0);
        // Ties, then back-to-back 3s and 8s
        for (int i = 0; i < 9; i++) step(8'd7);
        for (int i = 0; i < 9; i++) step(8'd3);
        for (int i = 0; i < 9; i++) step(8'd8);
        // Max in the middle / at the first position
        step(8'd10); step(8'd20); step(8'd30); step(8'd40); step(8'd99);
        step(8'd40); step(8'd30); step(8'd20); step(8'd10);
        step(8'd77); for (int i = 0; i < 8; i++) step(8'd12);

        // Mid-window reset: partial window of 200s must be discarded
        for (int i = 0; i < 4; i++) step(8'd200);
        rst = 1'b0;
        #1;
        check("midrst_pix", 32'(out_pix), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("midrst_hold_pix", 32'(out_pix), 32'h0);
        win_q.delete();
        held = '0;
        rst  = 1'b1;
        for (int i = 0; i < 9; i++) step(8'd5);

        // Sign-sensitive window: 0xFF x8 then 0x03
        for (int i = 0; i < 8; i++) step(8'hFF);
        step(8'h03);
`ifdef MAX_POOL_SIGNED_EN
        check("signed_win", 32'(out_pix), 32'h03);
`else
        check("unsigned_win", 32'(out_pix), 32'hFF);
`endif

        // A couple of random windows
        for (int i = 0; i < 18; i++) step(DW'($urandom_range(0, 255)));

        // 1x1 kernel: one-cycle delayed pass-through, valid every cycle
        begin
            logic [DW-1:0] k1_vals[3];
            k1_vals = '{8'd4, 8'd9, 8'd2};
            foreach (k1_vals[i]) begin
                pix1 = k1_vals[i];
                @(posedge clk);
                #1;
                check("k1_pix", 32'(out_pix1), 32'(k1_vals[i]));
                check("k1_valid", 32'(out_valid1), 32'h1);
            end
        end

        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_max_pooling_unit

`default_nettype wire
